// File: rtl/bj_pkg.sv
// Shared blackjack constants: card code width and deck position width.
package bj_pkg;
  localparam int CARD_W      = 4;
  localparam int DECK_ADDR_W = 6;
endpackage

// File: rtl/ram.sv
// Single-port 64 x 4 flip-flop RAM: synchronous write-first, registered read,
// asynchronous clear of every word and the output register.
module ram
  import bj_pkg::*;
#(
  parameter int DATA_W = CARD_W,
  parameter int ADDR_W = DECK_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  wr_sel;
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    wr_sel = '0;
    if (wr_en) wr_sel[addr] = 1'b1;
  end

  assign rd_word = mem[addr];

  // Storage lives in flops so the whole array can be cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      data_out <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) mem[i] <= data_in;
      end
      data_out <= wr_en ? data_in : rd_word;
    end
  end

endmodule

// File: tb/tb_ram.sv
// Randomized self-checking bench for ram against an array reference model.
module tb_ram;
  import bj_pkg::*;

  logic                   clk;
  logic                   rst;
  logic                   wr_en;
  logic [DECK_ADDR_W-1:0] addr;
  logic [CARD_W-1:0]      data_in;
  logic [CARD_W-1:0]      data_out;

  logic [CARD_W-1:0] model [64];
  int nChecks;
  int nErrors;

  ram dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [CARD_W-1:0] got,
                             input logic [CARD_W-1:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 64; i++) model[i] = '0;
  endtask

  // One access: drive on the falling edge, sample 1ns after the rising edge.
  task automatic applyStimulus(input string tag, input logic we, input int a,
                               input int d);
    logic [CARD_W-1:0] exp;
    @(negedge clk);
    wr_en   = we;
    addr    = DECK_ADDR_W'(a);
    data_in = CARD_W'(d);
    @(posedge clk);
    #1;
    if (we) begin
      model[a] = CARD_W'(d);
      exp = CARD_W'(d);
    end else begin
      exp = model[a];
    end
    checkOutput(tag, data_out, exp);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nChecks = 0;
    nErrors = 0;
    rst = 1'b1;
    wr_en = 1'b0;
    addr = '0;
    data_in = '0;
    clearModel();
    #1;
    checkOutput("reset_initial", data_out, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("wr_a1", 1'b1, 1, 4'hA);
    applyStimulus("wr_a2", 1'b1, 2, 4'hC);
    applyStimulus("rd_a1", 1'b0, 1, 0);
    applyStimulus("rd_a2", 1'b0, 2, 0);
    applyStimulus("wrfirst_a7", 1'b1, 7, 4'h5);
    applyStimulus("rd_a7", 1'b0, 7, 0);

    // Mid-run reset: data_out is nonzero here and must clear without a clock edge.
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("reset_async_out", data_out, 4'h0);
    clearModel();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("post_rst_a0", 1'b0, 0, 0);
    applyStimulus("post_rst_a1", 1'b0, 1, 0);
    applyStimulus("post_rst_a63", 1'b0, 63, 0);
    applyStimulus("post_rst_a7", 1'b0, 7, 0);

    for (int a = 0; a < 64; a++)
      applyStimulus("sweep_wr", 1'b1, a, (a % 16) ^ (a / 16));
    for (int a = 0; a < 64; a++)
      applyStimulus("sweep_rd", 1'b0, a, 0);

    applyStimulus("ovw_f", 1'b1, 10, 4'hF);
    applyStimulus("ovw_3", 1'b1, 10, 4'h3);
    applyStimulus("ovw_rd10", 1'b0, 10, 0);
    applyStimulus("iso_rd11", 1'b0, 11, 0);

    for (int i = 0; i < 300; i++)
      applyStimulus("random", 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                    int'($urandom_range(0, 15)));

    // Reset raised between edges while a write to address 4 is presented.
    applyStimulus("pre_wr_a4", 1'b1, 4, 4'h6);
    @(negedge clk);
    wr_en = 1'b1;
    addr = 6'd4;
    data_in = 4'h9;
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_during_wr", data_out, 4'h0);
    clearModel();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wr_en = 1'b0;
    applyStimulus("rst_wr_a4", 1'b0, 4, 0);
    applyStimulus("rst_wr_a10", 1'b0, 10, 0);

    for (int i = 0; i < 100; i++)
      applyStimulus("random2", 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                    int'($urandom_range(0, 15)));
    for (int a = 0; a < 64; a++)
      applyStimulus("final_rd", 1'b0, a, 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
